// File: rtl/instruction_fsm_if.sv
// rtl/instruction_fsm_if.sv - instruction FSM handshake and datapath control bundle
// Master drives s/load/in; slave (the FSM) drives w, selects, strobes and immediates.
interface instruction_fsm_if #(
  parameter int width = 16
);
  logic             s;
  logic             load;
  logic [width-1:0] in;
  logic             w;
  logic [2:0]       readnum;
  logic [2:0]       writenum;
  logic             loada;
  logic             loadb;
  logic             loadc;
  logic             loads;
  logic             write;
  logic             asel;
  logic             bsel;
  logic             vsel;
  logic [1:0]       shift;
  logic [1:0]       ALUop;
  logic [width-1:0] sximm5;
  logic [width-1:0] sximm8;

  modport master (
    output s, load, in,
    input  w, readnum, writenum, loada, loadb, loadc, loads, write,
    input  asel, bsel, vsel, shift, ALUop, sximm5, sximm8
  );

  modport slave (
    input  s, load, in,
    output w, readnum, writenum, loada, loadb, loadc, loads, write,
    output asel, bsel, vsel, shift, ALUop, sximm5, sximm8
  );
endinterface

// File: rtl/instruction_fsm.sv
// rtl/instruction_fsm.sv - instruction register, decoder and control sequencer
// Outputs are registered decodes of the next state so no input reaches an output combinationally.
module instruction_fsm #(
  parameter int width = 16
) (
  input  logic              clk,
  input  logic              reset,
  instruction_fsm_if.slave  bus
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GETA, S_GETB, S_EXEC, S_WREG, S_WIMM
  } state_t;

  typedef struct packed {
    logic       w;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       write;
    logic       asel;
    logic       bsel;
    logic       vsel;
    logic [1:0] shift;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{w: 1'b1, default: '0};

  state_t           state_q, state_d;
  logic [width-1:0] ir_q, ir_d;
  ctrl_t            ctrl_q, ctrl_d;

  function automatic logic is_mov_imm(input logic [width-1:0] ir);
    return ir[15:11] == 5'b110_10;
  endfunction

  function automatic logic is_mov_reg(input logic [width-1:0] ir);
    return ir[15:11] == 5'b110_00;
  endfunction

  function automatic logic is_alu(input logic [width-1:0] ir);
    return ir[15:13] == 3'b101;
  endfunction

  function automatic ctrl_t decode_ctrl(input state_t st, input logic [width-1:0] ir);
    ctrl_t c;
    c = '0;
    case (st)
      S_WAIT:   c.w = 1'b1;
      S_GETA: begin
        c.readnum = ir[10:8];
        c.loada   = 1'b1;
      end
      S_GETB: begin
        c.readnum = ir[2:0];
        c.loadb   = 1'b1;
      end
      S_EXEC: begin
        c.shift = ir[4:3];
        // MOV reg runs as ADD with A forced to zero
        if (is_mov_reg(ir)) begin
          c.alu_op = 2'b00;
          c.asel   = 1'b1;
        end else begin
          c.alu_op = ir[12:11];
        end
        if (is_alu(ir) && ir[12:11] == 2'b01) c.loads = 1'b1;
        else                                  c.loadc = 1'b1;
      end
      S_WREG: begin
        c.writenum = ir[7:5];
        c.write    = 1'b1;
      end
      S_WIMM: begin
        c.writenum = ir[10:8];
        c.vsel     = 1'b1;
        c.write    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    if (state_q == S_WAIT && bus.load) ir_d = bus.in;
    case (state_q)
      S_WAIT:   if (bus.s) state_d = S_DECODE;
      S_DECODE: begin
        if (is_mov_imm(ir_q))                                 state_d = S_WIMM;
        else if (is_mov_reg(ir_q))                            state_d = S_GETB;
        else if (is_alu(ir_q) && ir_q[12:11] == 2'b11)        state_d = S_GETB;
        else if (is_alu(ir_q))                                state_d = S_GETA;
        else                                                  state_d = S_WAIT;
      end
      S_GETA:   state_d = S_GETB;
      S_GETB:   state_d = S_EXEC;
      S_EXEC:   state_d = (ir_q[12:11] == 2'b01 && is_alu(ir_q)) ? S_WAIT : S_WREG;
      S_WREG:   state_d = S_WAIT;
      S_WIMM:   state_d = S_WAIT;
      default:  state_d = S_WAIT;
    endcase
    ctrl_d = decode_ctrl(state_d, ir_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
      ctrl_q  <= CTRL_IDLE;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.w        = ctrl_q.w;
  assign bus.readnum  = ctrl_q.readnum;
  assign bus.writenum = ctrl_q.writenum;
  assign bus.loada    = ctrl_q.loada;
  assign bus.loadb    = ctrl_q.loadb;
  assign bus.loadc    = ctrl_q.loadc;
  assign bus.loads    = ctrl_q.loads;
  assign bus.write    = ctrl_q.write;
  assign bus.asel     = ctrl_q.asel;
  assign bus.bsel     = ctrl_q.bsel;
  assign bus.vsel     = ctrl_q.vsel;
  assign bus.shift    = ctrl_q.shift;
  assign bus.ALUop    = ctrl_q.alu_op;
  assign bus.sximm8   = {{(width-8){ir_q[7]}}, ir_q[7:0]};
  assign bus.sximm5   = {{(width-5){ir_q[4]}}, ir_q[4:0]};

endmodule

// File: tb/tb_instruction_fsm.sv
// tb/tb_instruction_fsm.sv - directed vector bench for instruction_fsm
// Control vector layout: {readnum, writenum, loada, loadb, loadc, loads, write, asel, bsel, vsel, shift, ALUop}.
module tb_instruction_fsm;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  instruction_fsm_if #(.width(16)) bus ();

  instruction_fsm #(.width(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      instr;
    int               busy;
    logic [15:0]      sx8;
    logic [15:0]      sx5;
    logic [4:0][17:0] cyc;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [17:0] cv(input logic [2:0] rn, input logic [2:0] wn,
                                     input logic [7:0] strb, input logic [1:0] sh,
                                     input logic [1:0] op);
    return {rn, wn, strb, sh, op};
  endfunction

  function automatic vec_t mk(input logic [15:0] instr, input int busy,
                              input logic [15:0] sx8, input logic [15:0] sx5,
                              input logic [17:0] c0, input logic [17:0] c1,
                              input logic [17:0] c2, input logic [17:0] c3,
                              input logic [17:0] c4);
    vec_t v;
    v.instr = instr;
    v.busy  = busy;
    v.sx8   = sx8;
    v.sx5   = sx5;
    v.cyc   = {c4, c3, c2, c1, c0};
    return v;
  endfunction

  function automatic logic [17:0] cur();
    return {bus.readnum, bus.writenum, bus.loada, bus.loadb, bus.loadc, bus.loads,
            bus.write, bus.asel, bus.bsel, bus.vsel, bus.shift, bus.ALUop};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] word);
    @(negedge clk);
    bus.in   = word;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic pulse_s();
    bus.s = 1'b1;
    @(negedge clk);
    bus.s = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int   n;
    v = vecs[idx];
    do_load(v.instr);
    chk($sformatf("v%0d sximm8", idx), {16'h0, bus.sximm8}, {16'h0, v.sx8});
    chk($sformatf("v%0d sximm5", idx), {16'h0, bus.sximm5}, {16'h0, v.sx5});
    pulse_s();
    n = 0;
    while (bus.w == 1'b0 && n < 10) begin
      if (n < 5) chk($sformatf("v%0d cycle%0d ctrl", idx, n), {14'h0, cur()}, {14'h0, v.cyc[n]});
      n++;
      @(negedge clk);
    end
    chk($sformatf("v%0d busy cycles", idx), n, v.busy);
    chk($sformatf("v%0d idle ctrl", idx), {14'h0, cur()}, 32'h0);
  endtask

  localparam logic [17:0] Z = 18'h0;

  initial begin
    int n;
    vecs[0] = mk(16'hD007, 2, 16'h0007, 16'h0007,
                 Z, cv(3'd0, 3'd0, 8'b0000_1001, 2'b00, 2'b00), Z, Z, Z);
    vecs[1] = mk(16'hD1FE, 2, 16'hFFFE, 16'hFFFE,
                 Z, cv(3'd0, 3'd1, 8'b0000_1001, 2'b00, 2'b00), Z, Z, Z);
    vecs[2] = mk(16'hA148, 5, 16'h0048, 16'h0008,
                 Z, cv(3'd1, 3'd0, 8'b1000_0000, 2'b00, 2'b00),
                 cv(3'd0, 3'd0, 8'b0100_0000, 2'b00, 2'b00),
                 cv(3'd0, 3'd0, 8'b0010_0000, 2'b01, 2'b00),
                 cv(3'd0, 3'd2, 8'b0000_1000, 2'b00, 2'b00));
    vecs[3] = mk(16'hA801, 4, 16'h0001, 16'h0001,
                 Z, cv(3'd0, 3'd0, 8'b1000_0000, 2'b00, 2'b00),
                 cv(3'd1, 3'd0, 8'b0100_0000, 2'b00, 2'b00),
                 cv(3'd0, 3'd0, 8'b0001_0000, 2'b00, 2'b01), Z);
    vecs[4] = mk(16'hC072, 4, 16'h0072, 16'hFFF2,
                 Z, cv(3'd2, 3'd0, 8'b0100_0000, 2'b00, 2'b00),
                 cv(3'd0, 3'd0, 8'b0010_0100, 2'b10, 2'b00),
                 cv(3'd0, 3'd3, 8'b0000_1000, 2'b00, 2'b00), Z);
    vecs[5] = mk(16'hB586, 5, 16'hFF86, 16'h0006,
                 Z, cv(3'd5, 3'd0, 8'b1000_0000, 2'b00, 2'b00),
                 cv(3'd6, 3'd0, 8'b0100_0000, 2'b00, 2'b00),
                 cv(3'd0, 3'd0, 8'b0010_0000, 2'b00, 2'b10),
                 cv(3'd0, 3'd4, 8'b0000_1000, 2'b00, 2'b00));
    vecs[6] = mk(16'hB8F9, 4, 16'hFFF9, 16'hFFF9,
                 Z, cv(3'd1, 3'd0, 8'b0100_0000, 2'b00, 2'b00),
                 cv(3'd0, 3'd0, 8'b0010_0000, 2'b11, 2'b11),
                 cv(3'd0, 3'd7, 8'b0000_1000, 2'b00, 2'b00), Z);
    vecs[7] = mk(16'hE000, 1, 16'h0000, 16'h0000, Z, Z, Z, Z, Z);

    // reset dominates s and load
    reset    = 1'b1;
    bus.s    = 1'b1;
    bus.load = 1'b1;
    bus.in   = 16'hD007;
    repeat (2) @(negedge clk);
    chk("reset w", {31'h0, bus.w}, 32'h1);
    chk("reset ctrl", {14'h0, cur()}, 32'h0);
    chk("reset sximm8", {16'h0, bus.sximm8}, 32'h0);
    reset    = 1'b0;
    bus.s    = 1'b0;
    bus.load = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle w", {31'h0, bus.w}, 32'h1);
    end

    for (int i = 0; i < 8; i++) run_vec(i);

    // load and s together: DECODE uses the freshly loaded word
    do_load(16'hD007);
    bus.in   = 16'hD1FE;
    bus.load = 1'b1;
    bus.s    = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    bus.s    = 1'b0;
    @(negedge clk);
    chk("load+s wimm ctrl", {14'h0, cur()}, {14'h0, cv(3'd0, 3'd1, 8'b0000_1001, 2'b00, 2'b00)});
    @(negedge clk);

    // load while busy is ignored
    do_load(16'hA148);
    pulse_s();
    bus.in   = 16'hFFFF;
    bus.load = 1'b1;
    n = 0;
    while (bus.w == 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    bus.load = 1'b0;
    chk("busy load ignored sximm8", {16'h0, bus.sximm8}, 32'h0048);
    chk("busy load ignored cycles", n, 5);

    // reset in GETB of ADD abandons the write-back
    do_load(16'hA148);
    pulse_s();
    repeat (2) @(negedge clk);
    chk("pre-reset getb ctrl", {14'h0, cur()}, {14'h0, cv(3'd0, 3'd0, 8'b0100_0000, 2'b00, 2'b00)});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid reset w", {31'h0, bus.w}, 32'h1);
    chk("mid reset ctrl", {14'h0, cur()}, 32'h0);
    chk("mid reset sximm8", {16'h0, bus.sximm8}, 32'h0);
    repeat (4) begin
      @(negedge clk);
      chk("post reset write", {31'h0, bus.write}, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
